card_game_ctrl: RTL

CARD_GAME_CTRL -- requirements
Module: card_game_ctrl

---
 rtl/card_game_pkg.sv | 41 ++++
 rtl/card_lfsr.sv | 43 ++++
 rtl/card_game_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/card_game_pkg.sv
// Shared definitions for the two-player fruit-card bell game.
//   fruit_e    : fruit codes shown on c_value1/c_value2
//   LED_*      : round-winner codes shown on LED_sig
//   state_e    : controller FSM states
//   CARD_MAX   : highest count printed on a card
//   bell_valid : true when the visible cards justify ringing the bell
package card_game_pkg;

    typedef enum logic [1:0] {
        FRUIT_NONE  = 2'd0,
        FRUIT_RED   = 2'd1,
        FRUIT_GREEN = 2'd2,
        FRUIT_BLUE  = 2'd3
    } fruit_e;

    localparam logic [1:0] LED_NONE = 2'b00;
    localparam logic [1:0] LED_P1   = 2'b01;
    localparam logic [1:0] LED_P2   = 2'b10;

    localparam logic [2:0] CARD_MAX = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAL,
        ST_PLAY,
        ST_RESULT,
        ST_OVER
    } state_e;

    // Same fruit on both cards: counts must add to five.
    // Different fruits (or a missing card): some single card must show five.
    function automatic logic bell_valid(input logic [1:0] c1, input logic [1:0] c2,
                                        input logic [2:0] n1, input logic [2:0] n2);
        logic [3:0] sum;
        sum = {1'b0, n1} + {1'b0, n2};
        if ((c1 == c2) && (c1 != FRUIT_NONE))
            return sum == {1'b0, CARD_MAX};
        return (n1 == CARD_MAX) || (n2 == CARD_MAX);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that supplies random cards.
//   clk, rst   : clock, synchronous active-low reset (loads LFSR_SEED)
//   step       : advance the LFSR by one state this cycle
//   next_fruit : fruit decoded from the state the LFSR will hold after stepping
//   next_count : count 1..5 decoded from that same state
module card_lfsr
    import card_game_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [1:0] next_fruit,
    output logic [2:0] next_count
);

    logic [7:0] lfsr;
    logic [7:0] lfsr_next;
    logic [2:0] count_idx;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign count_idx = lfsr_next[4:2];

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else if (step)
            lfsr <= lfsr_next;
    end

    // The card is decoded from the post-step state so the dealer can register it
    // on the same edge that advances the LFSR. Fruit code 0 is remapped to red.
    always_comb begin
        next_fruit = lfsr_next[1:0];
        if (lfsr_next[1:0] == FRUIT_NONE)
            next_fruit = FRUIT_RED;
        // count_idx mod 5, plus one
        next_count = (count_idx >= CARD_MAX) ? count_idx - 3'd4 : count_idx + 3'd1;
    end

endmodule

// File: rtl/card_game_ctrl.sv
// Two-player fruit-card bell game controller.
//   clk, rst           : clock, synchronous active-low reset
//   btn_p1, btn_p2     : raw asynchronous bell buttons, active-high
//   c_value1/2         : top-card fruit per player (0 = no card)
//   n_value1/2         : top-card count per player (0 = no card)
//   LED_sig            : round winner (01 player 1, 10 player 2, 00 none)
//   score1, score2     : points, saturating at WIN_SCORE
//   game_over          : set once a score reaches WIN_SCORE
module card_game_ctrl
    import card_game_pkg::*;
#(
    parameter int         TICK_DIV  = 50_000_000,
    parameter int         WIN_SCORE = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_p1,
    input  logic       btn_p2,
    output logic [1:0] c_value1,
    output logic [1:0] c_value2,
    output logic [2:0] n_value1,
    output logic [2:0] n_value2,
    output logic [1:0] LED_sig,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

    state_e      state, state_n;
    logic [1:0]  sync1, sync2, sync3;  // bit 0 = player 1, bit 1 = player 2
    logic [1:0]  press;                // registered one-cycle press pulses
    logic [31:0] tick_cnt;
    logic        tick_done;
    logic        turn;                 // 0 = next card goes to player 1
    logic        bell, game_won;
    logic        deal, award_p1, award_p2, round_end;
    logic [1:0]  new_fruit;
    logic [2:0]  new_count;

    card_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step       (deal),
        .next_fruit (new_fruit),
        .next_count (new_count)
    );

    // Two synchronizer flops, one history flop, then a registered rising edge:
    // the pulse appears three edges after the button is first sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            press <= '0;
        end else begin
            sync1 <= {btn_p2, btn_p1};
            sync2 <= sync1;
            sync3 <= sync2;
            press <= sync2 & ~sync3;
        end
    end

    // Restarts from zero on every state change so PLAY and RESULT each last TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst)
            tick_cnt <= '0;
        else if (state_n != state)
            tick_cnt <= '0;
        else if (state == ST_PLAY || state == ST_RESULT)
            tick_cnt <= tick_cnt + 32'd1;
    end

    assign tick_done = (tick_cnt == 32'(TICK_DIV - 1));
    assign bell      = bell_valid(c_value1, c_value2, n_value1, n_value2);
    assign game_won  = (score1 == WIN4) || (score2 == WIN4);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        deal      = 1'b0;
        award_p1  = 1'b0;
        award_p2  = 1'b0;
        round_end = 1'b0;
        case (state)
            ST_IDLE:
                if (|press)
                    state_n = ST_DEAL;
            ST_DEAL: begin
                deal    = 1'b1;
                state_n = ST_PLAY;
            end
            ST_PLAY:
                // A single presser scores when right; a wrong ring hands the point over.
                // Simultaneous rings cancel out and play continues.
                if (press == 2'b01 || press == 2'b10) begin
                    award_p1 = (press[0] && bell) || (press[1] && !bell);
                    award_p2 = !award_p1;
                    state_n  = ST_RESULT;
                end else if (tick_done) begin
                    state_n = ST_DEAL;
                end
            ST_RESULT:
                if (tick_done) begin
                    round_end = 1'b1;
                    state_n   = game_won ? ST_OVER : ST_DEAL;
                end
            ST_OVER: ;
            default:
                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_value1  <= FRUIT_NONE;
            c_value2  <= FRUIT_NONE;
            n_value1  <= '0;
            n_value2  <= '0;
            LED_sig   <= LED_NONE;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            turn      <= 1'b0;
        end else begin
            if (deal) begin
                if (!turn) begin
                    c_value1 <= new_fruit;
                    n_value1 <= new_count;
                end else begin
                    c_value2 <= new_fruit;
                    n_value2 <= new_count;
                end
                turn <= ~turn;
            end
            if (award_p1) begin
                if (score1 != WIN4)
                    score1 <= score1 + 4'd1;
                if (score1 + 4'd1 == WIN4)
                    game_over <= 1'b1;
                LED_sig <= LED_P1;
            end
            if (award_p2) begin
                if (score2 != WIN4)
                    score2 <= score2 + 4'd1;
                if (score2 + 4'd1 == WIN4)
                    game_over <= 1'b1;
                LED_sig <= LED_P2;
            end
            if (round_end) begin
                c_value1 <= FRUIT_NONE;
                c_value2 <= FRUIT_NONE;
                n_value1 <= '0;
                n_value2 <= '0;
                turn     <= 1'b0;
                // Entering OVER the winner code stays lit; otherwise the LED goes dark.
                if (game_won)
                    LED_sig <= (score1 == WIN4) ? LED_P1 : LED_P2;
                else
                    LED_sig <= LED_NONE;
            end
        end
    end

endmodule
